// File: rtl/arm_pkg.sv
// Shared ARM datapath constants: instruction width, NOP/HALT encodings and
// the fetch-stage state enumeration.
// Latency: n/a (constants only). Backpressure: n/a.
package arm_pkg;

  localparam int ARM_INSTR_W = 32;

  // A64 NOP and HLT #0 encodings.
  localparam logic [ARM_INSTR_W-1:0] NOP_WORD  = 32'hD503201F;
  localparam logic [ARM_INSTR_W-1:0] HALT_WORD = 32'hD4400000;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: load, hold or advance by 4 each edge.
// Latency: new PC visible one edge after the select; output is the register.
// Backpressure: i_hold freezes the PC; i_load takes priority over i_hold.
// Ports:
//   clk, rst     - clock, async active-high reset (PC <- RESET_PC)
//   i_hold       - keep the current PC
//   i_load       - load i_load_addr
//   i_load_addr  - redirect address, used unmodified
//   o_pc         - current PC
module fetch_pc_reg #(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_hold,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_addr,
  output logic [ADDR_W-1:0] o_pc
);

  logic [ADDR_W-1:0] r_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (i_load) begin
      r_pc <= i_load_addr;
    end else if (!i_hold) begin
      // Wraps silently at 2^ADDR_W.
      r_pc <= r_pc + ADDR_W'(4);
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, imem address, IF/ID register, delivered count.
// Latency: word at PC p lands in IF/ID one edge later; first word two edges
// after reset release. Backpressure: stall freezes PC/IF/ID/count; a taken
// branch overrides stall, redirects the PC and flushes IF/ID to a bubble.
// Ports:
//   clk, pc_reset           - clock, async active-high reset
//   stall                   - hold PC and IF/ID
//   branch_taken/_target    - redirect PC, flush IF/ID
//   imem_addr / imem_instr  - combinational instruction memory port
//   if_id_pc/_instr/_valid  - IF/ID pipeline register
//   fetch_count             - saturating count of valid captures
//   halted                  - stage is in HALT
// Optional feature macro: FETCH_HALT_EN (HALT_WORD stops fetch until reset).
module fetch_stage
  import arm_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter int                INSTR_W  = ARM_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               pc_reset,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic               if_id_valid,
  output logic [31:0]        fetch_count,
  output logic               halted
);

  fetch_state_t       r_state;
  fetch_state_t       w_state_nxt;
  logic               w_pc_hold;
  logic               w_pc_load;
  logic               w_capture;
  logic               w_flush;
  logic [ADDR_W-1:0]  w_pc;

  logic [ADDR_W-1:0]  r_if_id_pc;
  logic [INSTR_W-1:0] r_if_id_instr;
  logic               r_if_id_valid;
  logic [31:0]        r_fetch_count;

  fetch_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk         (clk),
    .rst         (pc_reset),
    .i_hold      (w_pc_hold),
    .i_load      (w_pc_load),
    .i_load_addr (branch_target),
    .o_pc        (w_pc)
  );

  always_ff @(posedge clk or posedge pc_reset) begin
    if (pc_reset) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_hold   = 1'b1;
    w_pc_load   = 1'b0;
    w_capture   = 1'b0;
    w_flush     = 1'b0;
    case (r_state)
      // One dead cycle after reset: PC held, nothing captured.
      ST_BOOT: w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (branch_taken) begin
          // Branch beats stall and beats a fetched halt word.
          w_pc_load = 1'b1;
          w_pc_hold = 1'b0;
          w_flush   = 1'b1;
        end else if (!stall) begin
          w_capture = 1'b1;
          w_pc_hold = 1'b0;
`ifdef FETCH_HALT_EN
          // Halt word is still delivered and counted, but the PC parks on it.
          if (imem_instr == INSTR_W'(HALT_WORD)) begin
            w_pc_hold   = 1'b1;
            w_state_nxt = ST_HALT;
          end
`endif
        end
      end
      // Only reset leaves HALT; keep emitting bubbles meanwhile.
      ST_HALT: w_flush = 1'b1;
      default: w_state_nxt = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge pc_reset) begin
    if (pc_reset) begin
      r_if_id_pc    <= '0;
      r_if_id_instr <= INSTR_W'(NOP_WORD);
      r_if_id_valid <= 1'b0;
      r_fetch_count <= '0;
    end else if (w_flush) begin
      // if_id_pc is left as-is; a bubble's PC is meaningless.
      r_if_id_instr <= INSTR_W'(NOP_WORD);
      r_if_id_valid <= 1'b0;
    end else if (w_capture) begin
      r_if_id_pc    <= w_pc;
      r_if_id_instr <= imem_instr;
      r_if_id_valid <= 1'b1;
      if (r_fetch_count != 32'hFFFF_FFFF) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
    end
  end

  assign imem_addr   = w_pc;
  assign if_id_pc    = r_if_id_pc;
  assign if_id_instr = r_if_id_instr;
  assign if_id_valid = r_if_id_valid;
  assign fetch_count = r_fetch_count;

`ifdef FETCH_HALT_EN
  assign halted = (r_state == ST_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule
